// File: rtl/seq_sort_calc.sv
// seq_sort_calc: serial N-operand loader, odd-even transposition sorter and rule-selected signed calculator
module seq_sort_calc #(
    parameter int W  = 4,
    parameter int N  = 6,
    parameter int OW = 2*W+2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [2:0]           in_rule,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out
);
    localparam int CW = $clog2(N);
    localparam int L  = N-1;
    typedef enum logic [2:0] {IDLE, LOAD, SORT, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] s_q [N];
    logic [W-1:0] s_d [N];
    logic [CW-1:0] cnt_q, cnt_d, ph_q, ph_d;
    logic [2:0] rule_q, rule_d;
    logic signed [OW-1:0] out_q, out_d, res;
    logic [W-1:0] a, b, c, d, e, f;
    logic signed [OW-1:0] za, zb, zc, zd, ze, zf;
    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid = state_q == DONE;
    assign out       = out_q;
    always_comb begin
        case (rule_q[2:1])
            2'b00:   {a, b, c, d, e, f} = {s_q[0], s_q[1], s_q[2], s_q[L-2], s_q[L-1], s_q[L]};
            2'b01:   {a, b, c, d, e, f} = {s_q[1], s_q[L-2], s_q[L], s_q[0], s_q[2], s_q[L-1]};
            2'b10:   {a, b, c, d, e, f} = {s_q[0], s_q[2], s_q[L-1], s_q[L], s_q[L-2], s_q[1]};
            default: {a, b, c, d, e, f} = {s_q[L], s_q[L-2], s_q[1], s_q[0], s_q[2], s_q[L-1]};
        endcase
    end
    assign za = OW'(a);
    assign zb = OW'(b);
    assign zc = OW'(c);
    assign zd = OW'(d);
    assign ze = OW'(e);
    assign zf = OW'(f);
    assign res = rule_q[0] ? zb*zc - zc*zd + (zf >>> 1) : za*zb + zb*zc - (ze <<< 2);
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        rule_d  = rule_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (in_valid) begin
                rule_d  = in_rule;
                s_d[0]  = in_data;
                cnt_d   = CW'(1);
                state_d = LOAD;
            end
            LOAD: if (in_valid) begin
                s_d[cnt_q] = in_data;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) begin
                    ph_d    = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                // even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
                for (int i = 0; i < N-1; i++)
                    if ((i % 2 == 0) == !ph_q[0] && s_q[i] > s_q[i+1]) begin
                        s_d[i]   = s_q[i+1];
                        s_d[i+1] = s_q[i];
                    end
                ph_d = ph_q + CW'(1);
                if (ph_q == CW'(N-1)) state_d = CALC;
            end
            CALC: begin
                out_d   = res;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '{default: '0};
            cnt_q   <= '0;
            ph_q    <= '0;
            rule_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            rule_q  <= rule_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_seq_sort_calc.sv
// tb_seq_sort_calc: scoreboard bench for seq_sort_calc with W=4, N=6
module tb_seq_sort_calc;
    typedef int vec_t [6];
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, out_valid, in_ready;
    logic [3:0] in_data = 0;
    logic [2:0] in_rule = 0;
    logic signed [9:0] out;
    int total = 0, bad = 0;
    int q [$];
    seq_sort_calc #(.W(4), .N(6), .OW(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rule(in_rule), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1);
    end
    function automatic int model(vec_t v, logic [2:0] r);
        int s [6];
        int t, a, b, c, d, e, f;
        s = v;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        case (r[2:1])
            2'b00: begin a = s[0]; b = s[1]; c = s[2]; d = s[3]; e = s[4]; f = s[5]; end
            2'b01: begin a = s[1]; b = s[3]; c = s[5]; d = s[0]; e = s[2]; f = s[4]; end
            2'b10: begin a = s[0]; b = s[2]; c = s[4]; d = s[5]; e = s[3]; f = s[1]; end
            default: begin a = s[5]; b = s[3]; c = s[1]; d = s[0]; e = s[2]; f = s[4]; end
        endcase
        return r[0] ? b*c - c*d + f/2 : a*b + b*c - 4*e;
    endfunction
    // scoreboard: every consumed result must match the oldest outstanding job
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got %0d, required no result", out);
            end else begin
                int exp, got;
                exp = q.pop_front();
                got = int'(out);
                if (got !== exp) begin
                    bad++;
                    $display("FAIL result: got %0d, required %0d", got, exp);
                end
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive_job(input vec_t v, input logic [2:0] r, input int gap, input bit push);
        if (push) q.push_back(model(v, r));
        for (int k = 0; k < 6; k++) begin
            in_valid = 1;
            in_data  = v[k][3:0];
            in_rule  = (k == 0) ? r : 3'(~r);
            tick;
            in_valid = 0;
            repeat (gap) tick;
        end
    endtask
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
    endtask
    task automatic test_reset;
        rst = 1;
        repeat (3) tick;
        rst = 0;
        total++;
        if (out_valid !== 1'b0 || out !== 10'sd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: got valid=%b out=%0d ready=%b, required 0 0 1", out_valid, out, in_ready);
        end
    endtask
    task automatic test_basic;
        int n;
        drive_job('{3, 1, 4, 1, 5, 9}, 3'b000, 0, 1);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_last: got %b, required 0", in_ready);
        end
        wait_out(n);
        total++;
        if (n !== 7) begin
            bad++;
            $display("FAIL latency: got %0d edges, required 7", n);
        end
        tick;
    endtask
    task automatic test_rules;
        int n;
        logic [2:0] rules [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
        for (int i = 0; i < 4; i++) begin
            drive_job('{3, 1, 4, 1, 5, 9}, rules[i], 0, 1);
            wait_out(n);
            total++;
            if (n !== 7) begin
                bad++;
                $display("FAIL rule_latency: rule %b got %0d, required 7", rules[i], n);
            end
            tick;
        end
    endtask
    task automatic test_corners;
        int n;
        drive_job('{15, 15, 15, 15, 15, 15}, 3'b000, 0, 1);
        wait_out(n);
        tick;
        drive_job('{0, 0, 0, 0, 0, 0}, 3'b001, 0, 1);
        wait_out(n);
        tick;
        drive_job('{0, 0, 15, 15, 15, 15}, 3'b001, 0, 1);
        wait_out(n);
        tick;
        drive_job('{15, 14, 13, 12, 11, 10}, 3'b110, 0, 1);
        wait_out(n);
        tick;
        drive_job('{7, 0, 15, 2, 9, 4}, 3'b011, 1, 1);
        wait_out(n);
        tick;
    endtask
    task automatic test_bubbles;
        int n;
        vec_t v = '{3, 1, 4, 1, 5, 9};
        q.push_back(model(v, 3'b000));
        for (int k = 0; k < 6; k++) begin
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL bubble_ready: beat %0d got %b, required 1", k, in_ready);
            end
            in_valid = 1;
            in_data  = v[k][3:0];
            in_rule  = (k == 0) ? 3'b000 : 3'b111;
            tick;
            in_valid = 0;
            if (k < 5) repeat (2) tick;
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bubble_ready_drop: got %b, required 0", in_ready);
        end
        wait_out(n);
        tick;
    endtask
    task automatic test_backpressure;
        int n;
        logic signed [9:0] held;
        out_ready = 0;
        drive_job('{3, 1, 4, 1, 5, 9}, 3'b000, 0, 1);
        wait_out(n);
        held = out;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++;
            if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure: cycle %0d got valid=%b out=%0d ready=%b, required 1 %0d 0",
                         i, out_valid, out, in_ready, held);
            end
        end
        out_ready = 1;
        tick;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== held) begin
            bad++;
            $display("FAIL release: got valid=%b ready=%b out=%0d, required 0 1 %0d", out_valid, in_ready, out, held);
        end
        drive_job('{3, 1, 4, 1, 5, 9}, 3'b001, 0, 1);
        wait_out(n);
        tick;
    endtask
    task automatic test_reset_midjob;
        int n;
        vec_t v = '{3, 1, 4, 1, 5, 9};
        for (int k = 0; k < 3; k++) begin
            in_valid = 1;
            in_data  = v[k][3:0];
            in_rule  = 3'b000;
            tick;
        end
        in_valid = 0;
        rst = 1;
        tick;
        rst = 0;
        total++;
        if (out_valid !== 1'b0 || out !== 10'sd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_load: got valid=%b out=%0d ready=%b, required 0 0 1", out_valid, out, in_ready);
        end
        drive_job(v, 3'b000, 0, 0);
        repeat (2) tick;
        rst = 1;
        tick;
        rst = 0;
        total++;
        if (out_valid !== 1'b0 || out !== 10'sd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_sort: got valid=%b out=%0d ready=%b, required 0 0 1", out_valid, out, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL aborted_output: cycle %0d got valid=%b, required 0", i, out_valid);
            end
        end
        drive_job(v, 3'b000, 0, 1);
        wait_out(n);
        total++;
        if (n !== 7) begin
            bad++;
            $display("FAIL post_reset_latency: got %0d, required 7", n);
        end
        tick;
    endtask
    initial begin
        test_reset;
        test_basic;
        test_rules;
        test_corners;
        test_bubbles;
        test_backpressure;
        test_reset_midjob;
        repeat (3) tick;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL outstanding: got %0d results pending, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
